acc_cmem_responder: RTL and testbench
=====================================

# acc_cmem_responder

Memory-side responder for the accelerator Cmem channel. It accepts one load/store request at a time from an accelerator subsystem such as the FPU subsystem, and performs the access on the core's OBI data port. It then returns a single Cmem response carrying the extended read data, the valid bit range and the error status. It sits between the accelerator adapter's Cmem port and the data-memory arbiter.

## Interface
Parameters:
- ADDR_WIDTH, default acc_pkg::AddrWidth: width of the accelerator address tag, passed through unchanged.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- cmem_q_valid_i  in  1  request valid
- cmem_q_ready_o  out  1  request ready
- cmem_q_laddr_i  in  32  byte address
- cmem_q_wdata_i  in  32  store data, LSB-aligned
- cmem_q_width_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- cmem_q_req_type_i  in  acc_pkg::mem_req_type_e  READ or WRITE
- cmem_q_mode_i, cmem_q_spec_i, cmem_q_endoftransaction_i  in  1 each  accepted, ignored
- cmem_q_hart_id_i  in  32  hart tag
- cmem_q_addr_i  in  ADDR_WIDTH  accelerator tag
- cmem_p_valid_o  out  1  response valid
- cmem_p_ready_i  in  1  response ready
- cmem_p_rdata_o  out  32  extended load data; 0 for writes and errors
- cmem_p_range_o  out  5  highest valid data bit: 7, 15, 31
- cmem_p_status_o  out  1  0 ok, 1 error
- cmem_p_addr_o  out  ADDR_WIDTH  echoed tag
- cmem_p_hart_id_o  out  32  echoed hart id
- data_req_o  out  1  OBI request
- data_gnt_i  in  1  OBI grant
- data_addr_o  out  32  word-aligned address
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-shifted store data
- data_rvalid_i  in  1  OBI response valid
- data_rdata_i  in  32  raw read word
- data_err_i  in  1  bus error, qualified by data_rvalid_i

## Operation
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE
  - cmem_q_ready_o=1.
  - On handshake, register all request fields.
  - If the request is misaligned (H/HU with laddr[0]=1, W with laddr[1:0]≠0) or the width code is illegal: go to RSP with status=1 and rdata=0. No bus access occurs.
  - Otherwise go to REQ.
- REQ
  - data_req_o=1, with addr, we, be and wdata held stable until data_gnt_i.
  - On gnt, go to WAIT.
- WAIT
  - On data_rvalid_i, capture the result and go to RSP.
  - Read result: rdata = (data_rdata_i >> 8·off), sign- or zero-extended per width.
  - Write result: rdata=0.
  - status = data_err_i. On error, rdata=0.
- RSP
  - cmem_p_valid_o=1, with all response outputs stable.
  - On cmem_p_ready_i, go to IDLE.
- Lane rules, with off = laddr[1:0]:
  - data_addr_o = {laddr[31:2],2'b00}.
  - Byte enables: B/BU 4'b0001<<off; H/HU 4'b0011<<off; W 4'b1111.
  - data_wdata_o = wdata<<8·off.
  - data_we_o = (req_type==WRITE).
  - cmem_p_range_o: 7 for B/BU, 15 for H/HU, 31 for W and for errors.
- Only one transaction is outstanding at a time. A new request is never accepted before the previous response handshake completes.

## Timing
- Reset values: cmem_q_ready_o=1, cmem_p_valid_o=0, data_req_o=0, and all data/tag outputs 0. The FSM resets to IDLE.
- Reset asserted mid-transaction drops the transaction. The next cycle is IDLE. The bench keeps the memory model quiet across reset.
- Minimum aligned latency, with gnt in the first REQ cycle and rvalid one cycle later:
  - cycle 0: request handshake
  - cycle 1: data_req_o
  - cycle 2: rvalid
  - cycle 3: cmem_p_valid_o
- Misaligned or illegal request: cmem_p_valid_o in cycle 1.
- data_rvalid_i never arrives in the same cycle as gnt. rvalid outside WAIT is ignored.
- cmem_p_valid_o holds until ready. Data stays stable while valid && !ready.
- cmem_q_ready_o is combinational from the state only, never from cmem_q_valid_i.

## Structure
- acc_pkg gains:
  - cmem_width_e (B, H, W, BU, HU)
  - cmem_rsp_state_e (IDLE, REQ, WAIT, RSP)
  - constants CMEM_STATUS_OK/ERR
- Sub-module cmem_data_align: purely combinational.
  - Inputs: off, width, wdata, raw rdata.
  - Outputs: be, shifted wdata, extended rdata, range, misaligned flag.
- The top level holds the FSM and registers.

## Test plan
- LW at 0x100, gnt immediate, rdata 0xDEADBEEF → be=1111, addr=0x100; response rdata=0xDEADBEEF, range=31, status=0, valid on cycle 3.
- LB at 0x103, rdata 0x80FFFFFF → be=1000; rdata=0xFFFFFF80, range=7. LBU at the same address and data → rdata=0x00000080.
- SH at 0x102, wdata 0x1234ABCD → be=1100, data_wdata_o=0xABCD0000, we=1; response rdata=0, status=0, range=15.
- LW at 0x101 → no data_req_o; status=1, rdata=0, valid on cycle 1.
- gnt delayed 3 cycles and cmem_p_ready_i low for 2 cycles → req, addr and response fields are stable throughout. A second request is refused (cmem_q_ready_o=0) until the response handshake completes.
- data_err_i=1 on an LW, then rst_ni low while in REQ on the next access → first response has status=1, rdata=0. After reset, outputs are at reset values and a fresh LW completes normally.

Source files
------------

// File: rtl/acc_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg: shared accelerator types and constants for the Cmem channel. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package acc_pkg;

  localparam int AddrWidth = 32;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;

  // Encodings follow RISC-V load/store funct3.
  typedef enum logic [2:0] {
    CMEM_B  = 3'b000,
    CMEM_H  = 3'b001,
    CMEM_W  = 3'b010,
    CMEM_BU = 3'b100,
    CMEM_HU = 3'b101
  } cmem_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } cmem_rsp_state_e;

  localparam logic CMEM_STATUS_OK  = 1'b0;
  localparam logic CMEM_STATUS_ERR = 1'b1;

  localparam logic [4:0] CMEM_RANGE_B = 5'd7;
  localparam logic [4:0] CMEM_RANGE_H = 5'd15;
  localparam logic [4:0] CMEM_RANGE_W = 5'd31;

endpackage

`default_nettype wire

// File: rtl/cmem_data_align.sv
// ----------------------------------------------------------------------------
// cmem_data_align: byte-lane steering, load extension and alignment check. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmem_data_align
  import acc_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  width,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_ext,
  output logic [4:0]  bit_range,
  output logic        misaligned
);

  logic [31:0] rdata_sh;

  assign rdata_sh      = rdata_raw >> {off, 3'b000};
  assign wdata_shifted = wdata << {off, 3'b000};

  always_comb begin
    be         = 4'b0000;
    rdata_ext  = 32'h0;
    bit_range  = CMEM_RANGE_W;
    misaligned = 1'b0;
    case (width)
      CMEM_B: begin
        be        = 4'b0001 << off;
        rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
        bit_range = CMEM_RANGE_B;
      end
      CMEM_BU: begin
        be        = 4'b0001 << off;
        rdata_ext = {24'h0, rdata_sh[7:0]};
        bit_range = CMEM_RANGE_B;
      end
      CMEM_H: begin
        be         = 4'b0011 << off;
        rdata_ext  = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
        bit_range  = CMEM_RANGE_H;
        misaligned = off[0];
      end
      CMEM_HU: begin
        be         = 4'b0011 << off;
        rdata_ext  = {16'h0, rdata_sh[15:0]};
        bit_range  = CMEM_RANGE_H;
        misaligned = off[0];
      end
      CMEM_W: begin
        be         = 4'b1111;
        rdata_ext  = rdata_sh;
        bit_range  = CMEM_RANGE_W;
        misaligned = |off;
      end
      // Unused funct3 codes are treated like a misaligned access.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/acc_cmem_responder.sv
// ----------------------------------------------------------------------------
// acc_cmem_responder: one-at-a-time Cmem request to OBI data port bridge. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acc_cmem_responder
  import acc_pkg::*;
#(
  parameter int ADDR_WIDTH = acc_pkg::AddrWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmem_q_valid_i,
  output logic                  cmem_q_ready_o,
  input  logic [31:0]           cmem_q_laddr_i,
  input  logic [31:0]           cmem_q_wdata_i,
  input  logic [2:0]            cmem_q_width_i,
  input  mem_req_type_e         cmem_q_req_type_i,
  input  logic                  cmem_q_mode_i,
  input  logic                  cmem_q_spec_i,
  input  logic                  cmem_q_endoftransaction_i,
  input  logic [31:0]           cmem_q_hart_id_i,
  input  logic [ADDR_WIDTH-1:0] cmem_q_addr_i,
  output logic                  cmem_p_valid_o,
  input  logic                  cmem_p_ready_i,
  output logic [31:0]           cmem_p_rdata_o,
  output logic [4:0]            cmem_p_range_o,
  output logic                  cmem_p_status_o,
  output logic [ADDR_WIDTH-1:0] cmem_p_addr_o,
  output logic [31:0]           cmem_p_hart_id_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i
);

  cmem_rsp_state_e state, state_next;

  logic [31:0]           laddr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            width_q;
  logic                  we_q;
  logic [31:0]           hart_id_q;
  logic [ADDR_WIDTH-1:0] tag_q;
  logic [31:0]           rsp_rdata_q;
  logic [4:0]            rsp_range_q;
  logic                  rsp_status_q;

  logic        q_hs;
  logic        in_idle;
  logic [1:0]  al_off;
  logic [2:0]  al_width;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_wdata_sh;
  logic [31:0] al_rdata;
  logic [4:0]  al_range;
  logic        al_mis;

  logic unused_q_fields;
  assign unused_q_fields = ^{cmem_q_mode_i, cmem_q_spec_i, cmem_q_endoftransaction_i};

  assign in_idle = (state == IDLE);
  assign q_hs    = in_idle && cmem_q_valid_i;

  // In IDLE the aligner classifies the incoming request; afterwards it serves the held one.
  assign al_off   = in_idle ? cmem_q_laddr_i[1:0] : laddr_q[1:0];
  assign al_width = in_idle ? cmem_q_width_i      : width_q;
  assign al_wdata = in_idle ? cmem_q_wdata_i      : wdata_q;

  cmem_data_align u_align (
    .off           (al_off),
    .width         (al_width),
    .wdata         (al_wdata),
    .rdata_raw     (data_rdata_i),
    .be            (al_be),
    .wdata_shifted (al_wdata_sh),
    .rdata_ext     (al_rdata),
    .bit_range     (al_range),
    .misaligned    (al_mis)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmem_q_valid_i) state_next = al_mis ? RSP : REQ;
      REQ:  if (data_gnt_i)     state_next = WAIT;
      WAIT: if (data_rvalid_i)  state_next = RSP;
      RSP:  if (cmem_p_ready_i) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    cmem_q_ready_o = in_idle;
    cmem_p_valid_o = (state == RSP);
    data_req_o     = 1'b0;
    data_addr_o    = 32'h0;
    data_we_o      = 1'b0;
    data_be_o      = 4'b0000;
    data_wdata_o   = 32'h0;
    if (state == REQ) begin
      data_req_o   = 1'b1;
      data_addr_o  = {laddr_q[31:2], 2'b00};
      data_we_o    = we_q;
      data_be_o    = al_be;
      data_wdata_o = al_wdata_sh;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      laddr_q      <= 32'h0;
      wdata_q      <= 32'h0;
      width_q      <= 3'b000;
      we_q         <= 1'b0;
      hart_id_q    <= 32'h0;
      tag_q        <= '0;
      rsp_rdata_q  <= 32'h0;
      rsp_range_q  <= 5'd0;
      rsp_status_q <= CMEM_STATUS_OK;
    end else begin
      if (q_hs) begin
        laddr_q   <= cmem_q_laddr_i;
        wdata_q   <= cmem_q_wdata_i;
        width_q   <= cmem_q_width_i;
        we_q      <= (cmem_q_req_type_i == WRITE);
        hart_id_q <= cmem_q_hart_id_i;
        tag_q     <= cmem_q_addr_i;
        if (al_mis) begin
          rsp_rdata_q  <= 32'h0;
          rsp_range_q  <= CMEM_RANGE_W;
          rsp_status_q <= CMEM_STATUS_ERR;
        end
      end
      if ((state == WAIT) && data_rvalid_i) begin
        rsp_status_q <= data_err_i ? CMEM_STATUS_ERR : CMEM_STATUS_OK;
        rsp_rdata_q  <= (data_err_i || we_q) ? 32'h0 : al_rdata;
        rsp_range_q  <= data_err_i ? CMEM_RANGE_W : al_range;
      end
    end
  end

  assign cmem_p_rdata_o   = rsp_rdata_q;
  assign cmem_p_range_o   = rsp_range_q;
  assign cmem_p_status_o  = rsp_status_q;
  assign cmem_p_addr_o    = tag_q;
  assign cmem_p_hart_id_o = hart_id_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_cmem_responder.sv
// ----------------------------------------------------------------------------
// tb_acc_cmem_responder: table vectors, corner sequences and random traffic. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_acc_cmem_responder;
  import acc_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          q_valid, q_ready;
  logic [31:0]   q_laddr, q_wdata, q_hart;
  logic [2:0]    q_width;
  mem_req_type_e q_type;
  logic [31:0]   q_tag;
  logic          p_valid, p_ready, p_status;
  logic [31:0]   p_rdata, p_tag, p_hart;
  logic [4:0]    p_range;
  logic          d_req, d_gnt, d_we, d_rvalid, d_err;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic [3:0]    d_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_cmem_responder dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_n),
    .cmem_q_valid_i            (q_valid),
    .cmem_q_ready_o            (q_ready),
    .cmem_q_laddr_i            (q_laddr),
    .cmem_q_wdata_i            (q_wdata),
    .cmem_q_width_i            (q_width),
    .cmem_q_req_type_i         (q_type),
    .cmem_q_mode_i             (1'b0),
    .cmem_q_spec_i             (1'b0),
    .cmem_q_endoftransaction_i (1'b1),
    .cmem_q_hart_id_i          (q_hart),
    .cmem_q_addr_i             (q_tag),
    .cmem_p_valid_o            (p_valid),
    .cmem_p_ready_i            (p_ready),
    .cmem_p_rdata_o            (p_rdata),
    .cmem_p_range_o            (p_range),
    .cmem_p_status_o           (p_status),
    .cmem_p_addr_o             (p_tag),
    .cmem_p_hart_id_o          (p_hart),
    .data_req_o                (d_req),
    .data_gnt_i                (d_gnt),
    .data_addr_o               (d_addr),
    .data_we_o                 (d_we),
    .data_be_o                 (d_be),
    .data_wdata_o              (d_wdata),
    .data_rvalid_i             (d_rvalid),
    .data_rdata_i              (d_rdata),
    .data_err_i                (d_err)
  );

  typedef struct {
    logic [31:0] laddr;
    logic [31:0] wdata;
    logic [2:0]  width;
    logic        we;
    logic [31:0] raw;
    logic        err;
    int          gnt_dly;
    int          rdy_dly;
    bit          poke;
    logic [31:0] hart;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_range;
    logic        exp_status;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t tv(input logic [31:0] laddr, input logic [31:0] wdata,
                              input logic [2:0] width, input logic we, input logic [31:0] raw,
                              input logic err, input int gd, input int rd, input bit poke,
                              input logic mis, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wsh, input logic [31:0] rdata,
                              input logic [4:0] rng, input logic status);
    vec_t v;
    v.laddr = laddr; v.wdata = wdata; v.width = width; v.we = we; v.raw = raw; v.err = err;
    v.gnt_dly = gd; v.rdy_dly = rd; v.poke = poke; v.hart = 32'h1000 + laddr;
    v.exp_mis = mis; v.exp_addr = addr; v.exp_be = be; v.exp_wdata = wsh;
    v.exp_rdata = rdata; v.exp_range = rng; v.exp_status = status;
    return v;
  endfunction

  // Reference: access size in bytes, natural alignment, then arithmetic extension.
  function automatic vec_t model(input vec_t v);
    int     size;
    bit     sgn;
    bit     legal;
    int     off;
    longint val;
    legal = 1'b1;
    sgn   = 1'b0;
    case (v.width)
      3'd0:    begin size = 1; sgn = 1'b1; end
      3'd4:    size = 1;
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd5:    size = 2;
      3'd2:    size = 4;
      default: begin size = 4; legal = 1'b0; end
    endcase
    off         = int'(v.laddr % 4);
    v.exp_mis   = !legal || ((v.laddr % size) != 0);
    v.exp_addr  = v.laddr - off;
    v.exp_be    = 4'(((1 << size) - 1) << off);
    v.exp_wdata = v.wdata << (8 * off);
    if (v.exp_mis || v.err) begin
      v.exp_rdata  = 32'h0;
      v.exp_range  = 5'd31;
      v.exp_status = 1'b1;
    end else begin
      v.exp_range  = 5'(8 * size - 1);
      v.exp_status = 1'b0;
      if (v.we) begin
        v.exp_rdata = 32'h0;
      end else begin
        val = longint'(v.raw >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
        if (sgn && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
        v.exp_rdata = 32'(val);
      end
    end
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_q_ready"},  32'(q_ready),  32'd1);
    chk({tag, "_p_valid"},  32'(p_valid),  32'd0);
    chk({tag, "_d_req"},    32'(d_req),    32'd0);
    chk({tag, "_d_addr"},   d_addr,        32'd0);
    chk({tag, "_d_be_we"},  {27'd0, d_we, d_be}, 32'd0);
    chk({tag, "_d_wdata"},  d_wdata,       32'd0);
    chk({tag, "_p_rdata"},  p_rdata,       32'd0);
    chk({tag, "_p_rng_st"}, {26'd0, p_status, p_range}, 32'd0);
    chk({tag, "_p_tag"},    p_tag,         32'd0);
    chk({tag, "_p_hart"},   p_hart,        32'd0);
  endtask

  task automatic check_rsp(input string tag, input vec_t v);
    chk({tag, "_p_valid"},  32'(p_valid),  32'd1);
    chk({tag, "_p_rdata"},  p_rdata,       v.exp_rdata);
    chk({tag, "_p_range"},  32'(p_range),  32'(v.exp_range));
    chk({tag, "_p_status"}, 32'(p_status), 32'(v.exp_status));
    chk({tag, "_p_tag"},    p_tag,         ~v.laddr);
    chk({tag, "_p_hart"},   p_hart,        v.hart);
    chk({tag, "_q_ready"},  32'(q_ready),  32'd0);
  endtask

  task automatic check_bus(input string tag, input vec_t v);
    chk({tag, "_d_req"},   32'(d_req), 32'd1);
    chk({tag, "_d_addr"},  d_addr,     v.exp_addr);
    chk({tag, "_d_we"},    32'(d_we),  32'(v.we));
    chk({tag, "_d_be"},    32'(d_be),  32'(v.exp_be));
    chk({tag, "_d_wdata"}, d_wdata,    v.exp_wdata);
    chk({tag, "_q_ready"}, 32'(q_ready), 32'd0);
  endtask

  // Entered and left 1ns after a rising edge with the DUT idle.
  task automatic run(input vec_t v);
    int cyc;
    chk("idle_q_ready", 32'(q_ready), 32'd1);
    q_valid = 1'b1;
    q_laddr = v.laddr;
    q_wdata = v.wdata;
    q_width = v.width;
    q_type  = v.we ? WRITE : READ;
    q_hart  = v.hart;
    q_tag   = ~v.laddr;
    @(posedge clk); #1;
    q_valid = 1'b0;
    q_laddr = $urandom;
    q_wdata = $urandom;
    cyc = 1;
    if (v.exp_mis) begin
      chk("mis_no_req", 32'(d_req), 32'd0);
    end else begin
      check_bus("req", v);
      for (int i = 0; i < v.gnt_dly; i++) begin
        if (i == 0) begin
          d_rvalid = 1'b1;
          d_rdata  = 32'hCAFE0000;
        end
        if (v.poke) q_valid = 1'b1;
        @(posedge clk); #1;
        d_rvalid = 1'b0;
        cyc++;
        check_bus("req_hold", v);
      end
      d_gnt = 1'b1;
      @(posedge clk); #1;
      d_gnt = 1'b0;
      cyc++;
      chk("wait_no_req", 32'(d_req), 32'd0);
      d_rvalid = 1'b1;
      d_rdata  = v.raw;
      d_err    = v.err;
      @(posedge clk); #1;
      d_rvalid = 1'b0;
      d_err    = 1'b0;
      d_rdata  = $urandom;
      cyc++;
    end
    chk("rsp_valid", 32'(p_valid), 32'd1);
    if (v.exp_mis) chk("mis_latency", 32'(cyc), 32'd1);
    else if (v.gnt_dly == 0) chk("min_latency", 32'(cyc), 32'd3);
    for (int i = 0; i < v.rdy_dly; i++) begin
      check_rsp("rsp_hold", v);
      @(posedge clk); #1;
    end
    check_rsp("rsp", v);
    q_valid = 1'b0;
    p_ready = 1'b1;
    @(posedge clk); #1;
    p_ready = 1'b0;
    chk("rsp_done_p_valid", 32'(p_valid), 32'd0);
    chk("rsp_done_q_ready", 32'(q_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [2:0] wsel[7];
    wsel[0] = 3'd0; wsel[1] = 3'd1; wsel[2] = 3'd2; wsel[3] = 3'd4;
    wsel[4] = 3'd5; wsel[5] = 3'd3; wsel[6] = 3'd7;

    //             laddr         wdata         w     we    raw           err  gd rd poke mis  addr          be       wdata_sh      rdata         rng    st
    vecs[0]  = tv(32'h100, 32'h0,        3'd2, 1'b0, 32'hDEADBEEF, 1'b0, 0, 0, 0, 1'b0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 5'd31, 1'b0);
    vecs[1]  = tv(32'h103, 32'h0,        3'd0, 1'b0, 32'h80FFFFFF, 1'b0, 0, 0, 0, 1'b0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 5'd7,  1'b0);
    vecs[2]  = tv(32'h103, 32'h0,        3'd4, 1'b0, 32'h80FFFFFF, 1'b0, 1, 0, 0, 1'b0, 32'h100, 4'b1000, 32'h0,        32'h00000080, 5'd7,  1'b0);
    vecs[3]  = tv(32'h102, 32'h1234ABCD, 3'd1, 1'b1, 32'h55555555, 1'b0, 0, 1, 0, 1'b0, 32'h100, 4'b1100, 32'hABCD0000, 32'h0,        5'd15, 1'b0);
    vecs[4]  = tv(32'h101, 32'h0,        3'd2, 1'b0, 32'h0,        1'b0, 0, 0, 0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd31, 1'b1);
    vecs[5]  = tv(32'h200, 32'h0,        3'd2, 1'b0, 32'h0BADF00D, 1'b0, 3, 2, 1, 1'b0, 32'h200, 4'b1111, 32'h0,        32'h0BADF00D, 5'd31, 1'b0);
    vecs[6]  = tv(32'h106, 32'h0,        3'd1, 1'b0, 32'h80011234, 1'b0, 1, 1, 0, 1'b0, 32'h104, 4'b1100, 32'h0,        32'hFFFF8001, 5'd15, 1'b0);
    vecs[7]  = tv(32'h10D, 32'h000000AB, 3'd0, 1'b1, 32'h0,        1'b0, 2, 0, 0, 1'b0, 32'h10C, 4'b0010, 32'h0000AB00, 32'h0,        5'd7,  1'b0);
    vecs[8]  = tv(32'h108, 32'h0,        3'd3, 1'b0, 32'h0,        1'b0, 0, 1, 0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd31, 1'b1);
    vecs[9]  = tv(32'h10A, 32'h0,        3'd5, 1'b0, 32'hF00F1234, 1'b0, 0, 0, 0, 1'b0, 32'h108, 4'b1100, 32'h0,        32'h0000F00F, 5'd15, 1'b0);
    vecs[10] = tv(32'h300, 32'h0,        3'd2, 1'b0, 32'hFFFFFFFF, 1'b1, 0, 1, 0, 1'b0, 32'h300, 4'b1111, 32'h0,        32'h0,        5'd31, 1'b1);

    rst_n = 1'b0; q_valid = 1'b0; q_laddr = 32'h0; q_wdata = 32'h0; q_width = 3'd0;
    q_type = READ; q_hart = 32'h0; q_tag = 32'h0; p_ready = 1'b0;
    d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = 32'h0; d_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run(vecs[i]);

    // Reset while the next access sits in REQ drops it entirely.
    q_valid = 1'b1; q_laddr = 32'h400; q_width = 3'd2; q_type = READ;
    q_hart = 32'h77; q_tag = 32'h99;
    @(posedge clk); #1;
    q_valid = 1'b0;
    chk("mid_req_d_req", 32'(d_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("mid_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_rst");
    run(tv(32'h400, 32'h0, 3'd2, 1'b0, 32'h13579BDF, 1'b0, 0, 0, 0,
           1'b0, 32'h400, 4'b1111, 32'h0, 32'h13579BDF, 5'd31, 1'b0));

    for (int n = 0; n < 60; n++) begin
      v.laddr   = $urandom;
      if ($urandom_range(0, 1) == 0) v.laddr[1:0] = 2'b00;
      v.wdata   = $urandom;
      v.width   = wsel[$urandom_range(0, 6)];
      v.we      = 1'($urandom_range(0, 1));
      v.raw     = $urandom;
      v.err     = ($urandom_range(0, 7) == 0);
      v.gnt_dly = $urandom_range(0, 3);
      v.rdy_dly = $urandom_range(0, 2);
      v.poke    = 1'($urandom_range(0, 1));
      v.hart    = $urandom;
      run(model(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
